cpu_run_controller: RTL
=======================

Name: cpu_run_controller

Overview:
Hardware sequencer that drives the pipeline CPU's mode/udaddr debug interface. It replaces the bench-driven sequence with one session per start pulse: hold the CPU in reset, run it until stat reports STOP (or a cycle limit is hit), dump main memory, then dump the register file. Dumped words leave on a valid/ready stream toward a host link or bench scoreboard. Sits between the host/test harness and the CPU top.

Parameters:
MEM_WORDS, 512, number of memory words uploaded; udaddr runs 0..MEM_WORDS-1
REG_COUNT, 32, number of registers uploaded; udaddr = 4*i
RESET_CYCLES, 2, cycles the CPU is held in RESET_MODE before RUN_MODE (minimum 1)
MAX_CYCLES, 0, RUN-phase cycle limit; 0 = unlimited
CYCLE_W, 32, width of the cycle counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a session when idle
busy  out  1  high from start acceptance until return to IDLE
done  out  1  one-cycle pulse on entry to IDLE after a session
timed_out  out  1  sticky per session; set when MAX_CYCLES was reached
n_cycle  out  CYCLE_W  RUN-phase cycles counted; held after RUN ends
cpu_mode  out  2  to CPU mode: RUN=0, RESET=1, UPLOAD=2, STATUS=3
cpu_udaddr  out  32  to CPU udaddr
cpu_odata  in  32  from CPU odata
cpu_stat  in  2  from CPU stat: ALLOK=0, BUBBLE=1, STALL=2, STOP=3
out_valid  out  1  stream word valid
out_ready  in  1  stream sink ready
out_data  out  32  dumped word
out_kind  out  1  0 = memory word, 1 = register word
out_last  out  1  high with the final register word

Behaviour:
- Reset values: state IDLE, cpu_mode=RESET(1), cpu_udaddr=0, busy=0, done=0, timed_out=0, n_cycle=0, out_valid=0, out_data=0, out_kind=0, out_last=0.
- Async reset mid-session aborts at once. The stream word is dropped (out_valid=0) and the CPU returns to RESET mode.
- IDLE: cpu_mode=RESET. When start=1, clear n_cycle and timed_out, set busy, and go to HOLD. While busy=1, start is ignored.
- HOLD: cpu_mode=RESET for exactly RESET_CYCLES cycles, then go to RUN.
- RUN: cpu_mode=RUN. Each RUN cycle with cpu_stat!=STOP increments n_cycle, saturating at all-ones.
  - If cpu_stat==STOP, go to MEM_ADDR with udaddr=0. The STOP cycle is not counted.
  - If MAX_CYCLES!=0 and n_cycle==MAX_CYCLES, set timed_out and go to MEM_ADDR.
  - If STOP and the limit occur together, STOP wins and timed_out stays 0.
- Upload timing: the CPU read latency is 1 cycle. odata for an address is sampled on the cycle after that address is first driven.
- MEM_ADDR: cpu_mode=UPLOAD, cpu_udaddr=index. Next cycle go to MEM_CAP.
- MEM_CAP: latch cpu_odata into out_data, set out_kind=0, assert out_valid, go to MEM_WAIT.
- MEM_WAIT: hold out_data/out_valid stable and keep cpu_udaddr unchanged until out_valid&&out_ready.
  - On the handshake, drop out_valid.
  - If index==MEM_WORDS-1, go to REG_ADDR with index 0. Otherwise increment index and go to MEM_ADDR.
- REG_ADDR/REG_CAP/REG_WAIT: same protocol with cpu_mode=STATUS, cpu_udaddr=4*index, out_kind=1. out_last=1 when index==REG_COUNT-1.
  - After the last handshake, go to IDLE, pulse done for one cycle, drop busy, cpu_mode=RESET.
- Throughput: at best 3 cycles per word. out_ready held low stalls the session indefinitely without losing data.
- out_ready may be high before out_valid. No combinational path from out_ready to out_valid.
- The index counter has width clog2(max(MEM_WORDS,REG_COUNT)) and never wraps past its limit.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - mode constants (RUN_MODE, RESET_MODE, UPLOAD_MODE, STATUS_MODE)
  - stat constants (STAT_ALLOK, STAT_BUBBLE, STAT_STALL, STAT_STOP)
  - the controller state enum
- Mode and stat constants are shared with the CPU top and its bench.
- One sub-module, ctrl_out_reg: a single-entry output register (load, valid/ready hold, clear). It owns out_data, out_kind, out_last and out_valid.

Test Plan:
- Stub CPU raises STOP after 7 RUN cycles, out_ready=1 -> n_cycle=7, timed_out=0. Exactly 512+32 words arrive: memory udaddr 0..511, then register udaddr 0,4,..,124. out_last only on word 544. done pulses once.
- Stub odata = udaddr ^ 32'hA5A5_0000 -> every out_data matches. out_kind=0 for the first 512 words and 1 for the last 32.
- MAX_CYCLES=20 and CPU never stops -> timed_out=1, n_cycle=20, dump still completes. With STOP at cycle 20 instead -> timed_out=0.
- Random out_ready with 30% duty -> no word lost or duplicated; out_data/cpu_udaddr stable while valid&&!ready.
- reset_n low during MEM_WAIT at word 100 -> out_valid=0, cpu_mode=1, busy=0 immediately. A new start reruns the full session.
- start pulses while busy -> ignored, with one done pulse per accepted start. RESET_CYCLES=2 -> cpu_mode=1 for exactly 2 cycles before 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU debug interface and the run-controller state machine.
package cpu_ctrl_pkg;

    localparam logic [1:0] RUN_MODE    = 2'd0;
    localparam logic [1:0] RESET_MODE  = 2'd1;
    localparam logic [1:0] UPLOAD_MODE = 2'd2;
    localparam logic [1:0] STATUS_MODE = 2'd3;

    localparam logic [1:0] STAT_ALLOK  = 2'd0;
    localparam logic [1:0] STAT_BUBBLE = 2'd1;
    localparam logic [1:0] STAT_STALL  = 2'd2;
    localparam logic [1:0] STAT_STOP   = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_MEM_ADDR,
        ST_MEM_CAP,
        ST_MEM_WAIT,
        ST_REG_ADDR,
        ST_REG_CAP,
        ST_REG_WAIT
    } ctrl_state_e;

endpackage

// File: rtl/ctrl_out_reg.sv
// Single-entry output register for the dump stream; holds a word until the sink accepts it.
module ctrl_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_kind,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_kind,
    output logic              out_last
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_kind  <= 1'b0;
            out_last  <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_kind  <= load_kind;
            out_last  <= load_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Session sequencer: reset the CPU, run it to STOP or a cycle limit, then stream out
// main memory followed by the register file over a valid/ready link.
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WORDS    = 512,
    parameter int REG_COUNT    = 32,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 0,
    parameter int CYCLE_W      = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               timed_out,
    output logic [CYCLE_W-1:0] n_cycle,
    output logic [1:0]         cpu_mode,
    output logic [31:0]        cpu_udaddr,
    input  logic [31:0]        cpu_odata,
    input  logic [1:0]         cpu_stat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic               out_kind,
    output logic               out_last
);

    localparam int IDX_N  = (MEM_WORDS > REG_COUNT) ? MEM_WORDS : REG_COUNT;
    localparam int IDX_W  = (IDX_N > 1) ? $clog2(IDX_N) : 1;
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    ctrl_state_e        state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [HOLD_W-1:0]  hold_cnt, hold_d;
    logic [CYCLE_W-1:0] ncyc_d;
    logic               tout_d, done_d;
    logic               load, load_kind, load_last, clear;
    logic               hs;

    assign busy = (state != ST_IDLE);
    assign hs   = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            hold_cnt  <= '0;
            n_cycle   <= '0;
            timed_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            hold_cnt  <= hold_d;
            n_cycle   <= ncyc_d;
            timed_out <= tout_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        hold_d     = hold_cnt;
        ncyc_d     = n_cycle;
        tout_d     = timed_out;
        done_d     = 1'b0;
        load       = 1'b0;
        load_kind  = 1'b0;
        load_last  = 1'b0;
        clear      = 1'b0;
        cpu_mode   = RESET_MODE;
        cpu_udaddr = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    ncyc_d  = '0;
                    tout_d  = 1'b0;
                    hold_d  = '0;
                    idx_d   = '0;
                    clear   = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) state_d = ST_RUN;
                else hold_d = hold_cnt + 1'b1;
            end
            ST_RUN: begin
                cpu_mode = RUN_MODE;
                // STOP is checked first so a simultaneous limit hit is not reported as a timeout
                if (cpu_stat == STAT_STOP) begin
                    idx_d   = '0;
                    state_d = ST_MEM_ADDR;
                end else if ((MAX_CYCLES != 0) && (n_cycle == CYCLE_W'(MAX_CYCLES))) begin
                    tout_d  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_MEM_ADDR;
                end else if (n_cycle != '1) begin
                    ncyc_d = n_cycle + 1'b1;
                end
            end
            ST_MEM_ADDR: begin
                cpu_mode   = UPLOAD_MODE;
                cpu_udaddr = 32'(idx);
                state_d    = ST_MEM_CAP;
            end
            ST_MEM_CAP: begin
                cpu_mode   = UPLOAD_MODE;
                cpu_udaddr = 32'(idx);
                load       = 1'b1;
                state_d    = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                cpu_mode   = UPLOAD_MODE;
                cpu_udaddr = 32'(idx);
                if (hs) begin
                    if (idx == IDX_W'(MEM_WORDS - 1)) begin
                        idx_d   = '0;
                        state_d = ST_REG_ADDR;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = ST_MEM_ADDR;
                    end
                end
            end
            ST_REG_ADDR: begin
                cpu_mode   = STATUS_MODE;
                cpu_udaddr = 32'(idx) << 2;
                state_d    = ST_REG_CAP;
            end
            ST_REG_CAP: begin
                cpu_mode   = STATUS_MODE;
                cpu_udaddr = 32'(idx) << 2;
                load       = 1'b1;
                load_kind  = 1'b1;
                load_last  = (idx == IDX_W'(REG_COUNT - 1));
                state_d    = ST_REG_WAIT;
            end
            ST_REG_WAIT: begin
                cpu_mode   = STATUS_MODE;
                cpu_udaddr = 32'(idx) << 2;
                if (hs) begin
                    if (idx == IDX_W'(REG_COUNT - 1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = ST_REG_ADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ctrl_out_reg #(.DATA_W(32)) u_out (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .load      (load),
        .load_data (cpu_odata),
        .load_kind (load_kind),
        .load_last (load_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_kind  (out_kind),
        .out_last  (out_last)
    );

endmodule
